// File: rtl/prefix_fetch_queue_if.sv
// Fetch-side, index-operand, decode-side and status signals of the prefix fetch queue.
// The slave modport is the queue itself; master is whoever drives fetch/decode.
interface prefix_fetch_queue_if #(
  parameter int WORD_W = 15,
  parameter int PC_W   = 12,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic [PC_W-1:0]   in_pc;

  logic              idx_req;
  logic [ADDR_W-1:0] idx_addr;
  logic              idx_valid;
  logic [WORD_W-1:0] idx_data;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_start_pc;
  logic              out_extend;
  logic              out_indexed;

  logic              prefix_busy;
  logic [CNT_W-1:0]  count;
  logic              err_stray_idx;

  modport slave (
    input  in_valid, in_word, in_pc, idx_valid, idx_data, out_ready,
    output in_ready, idx_req, idx_addr, out_valid, out_word, out_pc,
           out_start_pc, out_extend, out_indexed, prefix_busy, count,
           err_stray_idx
  );

  modport master (
    output in_valid, in_word, in_pc, idx_valid, idx_data, out_ready,
    input  in_ready, idx_req, idx_addr, out_valid, out_word, out_pc,
           out_start_pc, out_extend, out_indexed, prefix_busy, count,
           err_stray_idx
  );
endinterface

// File: rtl/prefix_fetch_queue.sv
// Fetch-to-decode front end: folds AGC EXTEND/INDEX prefixes into the following
// executable word and queues only executable words, tagged with prefix state.
module prefix_fetch_queue #(
  parameter int WORD_W = 15,
  parameter int PC_W   = 12,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic clock,
  input  logic rst,
  input  logic flush,
  prefix_fetch_queue_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] EXTEND_WORD = WORD_W'(6);

  typedef enum logic [1:0] {IDLE, EXT, IDX_WAIT, IDX_HOLD} state_t;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   start_pc;
    logic              extend;
    logic              indexed;
  } entry_t;

  state_t            state;
  state_t            state_nx;
  logic              ext_f;
  logic [WORD_W-1:0] offset;
  logic [PC_W-1:0]   start_pc;
  logic [ADDR_W-1:0] addr_r;
  logic              err_r;

  entry_t            mem [DEPTH];
  entry_t            head;
  entry_t            new_entry;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  logic [WORD_W-1:0] eff;
  logic              is_ext;
  logic              is_idx;
  logic [ADDR_W-1:0] new_addr;
  logic              ready;
  logic              accept;
  logic              push;
  logic              pop;
  logic              idx_take;

  assign ready    = (state != IDX_WAIT) && (cnt < CNT_W'(DEPTH));
  assign accept   = bus.in_valid && ready && !flush && !rst;
  assign idx_take = (state == IDX_WAIT) && bus.idx_valid && !flush && !rst;
  assign push     = accept && !is_ext && !is_idx;
  assign pop      = (cnt != '0) && bus.out_ready && !flush && !rst;

  // State register
  always_ff @(posedge clock) begin
    if (rst || flush) state <= IDLE;
    else              state <= state_nx;
  end

  // Next-state and word decode; only the offset-adjusted word is decoded
  always_comb begin
    eff      = (state == IDX_HOLD) ? bus.in_word + offset : bus.in_word;
    is_ext   = ((state == IDLE) || (state == EXT)) && (eff == EXTEND_WORD);
    is_idx   = (eff[WORD_W-1 -: 3] == 3'd5) && (ext_f || (eff[11:10] == 2'b00));
    new_addr = ext_f ? eff[ADDR_W-1:0] : ADDR_W'(eff[9:0]);
    state_nx = state;
    if (accept) begin
      if (is_ext)      state_nx = EXT;
      else if (is_idx) state_nx = IDX_WAIT;
      else             state_nx = IDLE;
    end else if (idx_take) begin
      state_nx = IDX_HOLD;
    end
  end

  // Outputs
  always_comb begin
    head             = mem[rd_ptr];
    bus.in_ready     = ready;
    bus.idx_req      = accept && is_idx;
    bus.idx_addr     = (accept && is_idx) ? new_addr : addr_r;
    bus.prefix_busy  = (state != IDLE);
    bus.count        = cnt;
    bus.err_stray_idx = err_r;
    bus.out_valid    = (cnt != '0);
    bus.out_word     = bus.out_valid ? head.word     : '0;
    bus.out_pc       = bus.out_valid ? head.pc       : '0;
    bus.out_start_pc = bus.out_valid ? head.start_pc : '0;
    bus.out_extend   = bus.out_valid && head.extend;
    bus.out_indexed  = bus.out_valid && head.indexed;
  end

  // Prefix context: extracode flag, index offset, restart pc, operand address
  always_ff @(posedge clock) begin
    if (rst || flush) begin
      ext_f    <= 1'b0;
      offset   <= '0;
      start_pc <= '0;
      addr_r   <= '0;
    end else if (accept) begin
      if (state == IDLE) start_pc <= bus.in_pc;
      if (is_ext) begin
        ext_f <= 1'b1;
      end else if (is_idx) begin
        addr_r <= new_addr;
        offset <= '0;
      end else begin
        ext_f  <= 1'b0;
        offset <= '0;
      end
    end else if (idx_take) begin
      offset <= bus.idx_data;
    end
  end

  // Sticky stray-response flag survives flush
  always_ff @(posedge clock) begin
    if (rst)
      err_r <= 1'b0;
    else if (!flush && bus.idx_valid && (state != IDX_WAIT))
      err_r <= 1'b1;
  end

  always_comb begin
    new_entry.word     = eff;
    new_entry.pc       = bus.in_pc;
    new_entry.start_pc = (state == IDLE) ? bus.in_pc : start_pc;
    new_entry.extend   = ext_f;
    new_entry.indexed  = (state == IDX_HOLD);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clock) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule
